// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Drains the read side of a show-ahead FIFO (fifo_rd / fifo_empty / fifo_data)
// and presents the words as a valid/ready stream with packet framing: m_last
// marks every BURST-th accepted beat. A two-entry buffer (head + skid) keeps
// one word per clock flowing while fifo_rd stays independent of m_ready.
//
// Build option: define FIFO_STREAM_READER_FLUSH_EN to close a partial packet
// when the reader is disabled (m_last forced on the last buffered word).
module fifo_stream_reader #(
  parameter int B     = 8,
  parameter int BURST = 4,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          fifo_empty,
  input  logic [B-1:0]  fifo_data,
  output logic          fifo_rd,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [B-1:0]  m_data,
  output logic          m_last,
  output logic          busy,
  output logic [CW-1:0] word_cnt
);

  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    occ;
  logic [B-1:0]  entry0;
  logic [B-1:0]  entry1;
  logic [BW-1:0] beat;

  logic push;
  logic pop;
  logic at_last;
  logic flush_close;

  // Fetch depends only on registered state/occupancy and the FIFO flag, so
  // the pop strobe to the FIFO never sees a combinational path from m_ready.
  assign fifo_rd = (state == RUN) & ~fifo_empty & (occ != 2'd2);
  assign push    = fifo_rd;

  assign m_valid = (occ != 2'd0);
  assign m_data  = entry0;
  assign pop     = m_valid & m_ready;
  assign at_last = (beat == LAST_BEAT);

`ifdef FIFO_STREAM_READER_FLUSH_EN
  // The only word left while draining closes whatever packet is still open.
  assign flush_close = (state == DRAIN) & (occ == 2'd1) & ~at_last;
`else
  assign flush_close = 1'b0;
`endif

  assign m_last = m_valid & (at_last | flush_close);

  // Control FSM: IDLE -> RUN on enable, RUN -> DRAIN when enable drops,
  // DRAIN -> IDLE once the last buffered word leaves; busy is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all clocked state uses non-blocking assignment so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (enable) begin
            state <= RUN;
          end else if ((occ == 2'd0) || ((occ == 2'd1) && pop)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Head/skid buffer: head always drives m_data, skid only fills when the
  // head is stalled and a fetched word arrives in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the two data entries are reset only because m_data must read 0
    // out of reset; a deeper storage array would normally be left unreset.
    if (!rst_n) begin
      occ    <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      case (occ)
        2'd0: begin
          if (push) begin
            entry0 <= fifo_data;
            occ    <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            entry0 <= fifo_data;
          end else if (push) begin
            entry1 <= fifo_data;
            occ    <= 2'd2;
          end else if (pop) begin
            occ    <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            entry0 <= entry1;
            occ    <= 2'd1;
          end
        end
        default: begin
          occ <= 2'd0;
        end
      endcase
    end
  end

  // Packet beat position and total transfer count advance on each accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat     <= '0;
      word_cnt <= '0;
    end else if (pop) begin
      word_cnt <= word_cnt + 1'b1;
      beat     <= (at_last || flush_close) ? '0 : beat + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
// Directed bench for fifo_stream_reader: a queue models the show-ahead FIFO,
// a scoreboard queue holds the expected (data, last) pairs pushed at load time
// and popped on each accepted beat. Two instances: BURST=4/CW=16 and
// BURST=1/CW=4, selected by 'sel' onto the shared FIFO model.
module tb_fifo_stream_reader;

`ifdef FIFO_STREAM_READER_FLUSH_EN
  localparam logic FLUSH = 1'b1;
`else
  localparam logic FLUSH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       m_ready;
  logic       sel;
  logic       empty_m;
  logic [7:0] fifo_data;
  logic       fifo_empty0;
  logic       fifo_empty1;

  logic        rd0, valid0, last0, busy0;
  logic [7:0]  data0;
  logic [15:0] cnt0;
  logic        rd1, valid1, last1, busy1;
  logic [7:0]  data1;
  logic [3:0]  cnt1;

  always #5 clk = ~clk;

  assign fifo_empty0 = sel | empty_m;
  assign fifo_empty1 = ~sel | empty_m;

  fifo_stream_reader #(.B(8), .BURST(4), .CW(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fifo_empty(fifo_empty0), .fifo_data(fifo_data), .fifo_rd(rd0),
    .m_valid(valid0), .m_ready(m_ready), .m_data(data0), .m_last(last0),
    .busy(busy0), .word_cnt(cnt0)
  );

  fifo_stream_reader #(.B(8), .BURST(1), .CW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fifo_empty(fifo_empty1), .fifo_data(fifo_data), .fifo_rd(rd1),
    .m_valid(valid1), .m_ready(m_ready), .m_data(data1), .m_last(last1),
    .busy(busy1), .word_cnt(cnt1)
  );

  // Observed outputs of whichever instance is currently attached to the FIFO.
  logic        o_rd, o_valid, o_last, o_busy;
  logic [7:0]  o_data;
  logic [15:0] o_cnt;

  always_comb begin
    o_rd    = sel ? rd1    : rd0;
    o_valid = sel ? valid1 : valid0;
    o_last  = sel ? last1  : last0;
    o_busy  = sel ? busy1  : busy0;
    o_data  = sel ? data1  : data0;
    o_cnt   = sel ? {12'd0, cnt1} : cnt0;
  end

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fq[$];

  int vectors = 0;
  int errors  = 0;
  int inflight = 0;
  int ph_rd, ph_acc, rd_run, rd_max, acc_run, acc_max;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'd0;
  logic       prev_last  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd_fifo();
    empty_m   = (fq.size() == 0);
    fifo_data = empty_m ? 8'h00 : fq[0];
  endtask

  task automatic load(input logic [7:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    fq.push_back(d);
    sb.push_back(e);
    upd_fifo();
  endtask

  task automatic phase_reset();
    ph_rd = 0; ph_acc = 0; rd_run = 0; rd_max = 0; acc_run = 0; acc_max = 0;
  endtask

  // One clock: sample at the falling edge, then let the FIFO model react to
  // the pop strobe just after the rising edge.
  task automatic tick();
    logic rd, pp;
    exp_t e;
    @(negedge clk);
    rd = o_rd;
    pp = o_valid & m_ready;
    check("rd_while_empty", 32'(rd & empty_m), 32'd0);
    check("occ_le_2", 32'(inflight <= 2), 32'd1);
    if (inflight == 2) check("rd_at_occ2", 32'(rd), 32'd0);
    check("valid_vs_buffered", 32'(o_valid), 32'(inflight != 0));
    if (prev_stall) begin
      check("stall_data", 32'(o_data), 32'(prev_data));
      check("stall_last", 32'(o_last), 32'(prev_last));
    end
    if (pp) begin
      check("extra_word", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("m_data", 32'(o_data), 32'(e.d));
        check("m_last", 32'(o_last), 32'(e.l));
      end
    end
    prev_stall = o_valid & ~m_ready;
    prev_data  = o_data;
    prev_last  = o_last;
    if (rd) begin
      ph_rd++; rd_run++;
      if (rd_run > rd_max) rd_max = rd_run;
    end else begin
      rd_run = 0;
    end
    if (pp) begin
      ph_acc++; acc_run++;
      if (acc_run > acc_max) acc_max = acc_run;
    end else begin
      acc_run = 0;
    end
    @(posedge clk);
    #1;
    if (rd) begin
      if (fq.size() > 0) void'(fq.pop_front());
      inflight++;
    end
    if (pp) inflight--;
    upd_fifo();
  endtask

  task automatic run_until_empty(input int max_cycles);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b0;
    m_ready = 1'b0;
    sel     = 1'b0;
    upd_fifo();

    // Reset state, with words already waiting in the FIFO.
    for (int i = 1; i <= 8; i++) load(8'(i), (i % 4) == 0);
    #12;
    check("rst_m_valid", 32'(valid0), 32'd0);
    check("rst_fifo_rd", 32'(rd0), 32'd0);
    check("rst_m_last", 32'(last0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_word_cnt", 32'(cnt0), 32'd0);
    check("rst_m_data", 32'(data0), 32'd0);
    check("rst_word_cnt1", 32'(cnt1), 32'd0);

    // Streaming at full rate.
    enable  = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    phase_reset();
    run_until_empty(30);
    check("full_rate_rd_run", 32'(rd_max), 32'd8);
    check("full_rate_acc_run", 32'(acc_max), 32'd8);
    check("full_rate_word_cnt", 32'(cnt0), 32'd8);
    check("full_rate_busy", 32'(busy0), 32'd1);
    check("full_rate_empty", 32'(valid0), 32'd0);

    // Downstream alternating ready/stall.
    phase_reset();
    for (int i = 1; i <= 8; i++) load(8'(i), (i % 4) == 0);
    for (int n = 0; n < 40 && sb.size() != 0; n++) begin
      m_ready = (n % 2) == 0;
      tick();
    end
    check("toggle_drain", 32'(sb.size()), 32'd0);
    check("toggle_word_cnt", 32'(cnt0), 32'd16);

    // Downstream blocked: only two fetches fill the buffer.
    phase_reset();
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) load(8'(i), (i % 4) == 0);
    repeat (10) tick();
    check("blocked_rd_pulses", 32'(ph_rd), 32'd2);
    check("blocked_rd_now", 32'(rd0), 32'd0);
    check("blocked_valid", 32'(valid0), 32'd1);
    m_ready = 1'b1;
    run_until_empty(40);
    check("blocked_word_cnt", 32'(cnt0), 32'd24);

    // Enable drops on the 6th fetch with two words buffered.
    phase_reset();
    for (int i = 1; i <= 8; i++) begin
      logic l;
      case (i)
        4:       l = 1'b1;
        6:       l = FLUSH;
        8:       l = ~FLUSH;
        default: l = 1'b0;
      endcase
      load(8'h10 + 8'(i), l);
    end
    for (int n = 0; n < 12; n++) begin
      enable  = (ph_rd < 5);
      m_ready = (ph_acc < 4) || (ph_rd >= 6);
      tick();
    end
    check("drain_rd_pulses", 32'(ph_rd), 32'd6);
    check("drain_accepted", 32'(ph_acc), 32'd6);
    check("drain_busy", 32'(busy0), 32'd0);
    check("drain_valid", 32'(valid0), 32'd0);
    check("drain_rd_idle", 32'(rd0), 32'd0);
    check("drain_word_cnt", 32'(cnt0), 32'd30);
    enable = 1'b1;
    run_until_empty(20);
    check("reenable_word_cnt", 32'(cnt0), 32'd32);

    // Asynchronous reset with both buffer entries full.
    phase_reset();
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) load(8'h20 + 8'(i), 1'b0);
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(valid0), 32'd0);
    check("async_rst_fifo_rd", 32'(rd0), 32'd0);
    check("async_rst_busy", 32'(busy0), 32'd0);
    check("async_rst_word_cnt", 32'(cnt0), 32'd0);
    check("async_rst_last", 32'(last0), 32'd0);
    sb.delete();
    inflight   = 0;
    prev_stall = 1'b0;
    for (int i = 0; i < fq.size(); i++) begin
      exp_t e;
      e.d = fq[i];
      e.l = (i == 3);
      sb.push_back(e);
    end
    m_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    run_until_empty(40);
    check("post_rst_word_cnt", 32'(cnt0), 32'd6);

    // BURST=1, CW=4 instance: every beat is last and the counter wraps.
    sel = 1'b1;
    phase_reset();
    for (int i = 1; i <= 20; i++) load(8'h40 + 8'(i), 1'b1);
    run_until_empty(60);
    check("burst1_word_cnt_wrap", 32'(cnt1), 32'd4);
    check("burst1_idle_valid", 32'(valid1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Drains the read side of the team's show-ahead FIFO (rd/empty/r_data) and presents the words as a valid/ready stream.
- Adds packet framing: m_last asserted every BURST beats.
- 2-entry output buffer (head + skid) sustains 1 word/cycle while keeping fifo_rd independent of m_ready.
- Sits between a FIFO instance and any downstream stream consumer.

Parameters:
- B, 8, data word width in bits; matches the FIFO word width.
- BURST, 4, beats per packet; legal range 1..256.
- CW, 16, width of the transferred-word counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous reset, active-low
- enable  input  1  1 = fetch from FIFO; 0 = stop fetching and drain the buffer
- fifo_empty  input  1  FIFO empty flag
- fifo_data  input  B  FIFO head word; valid whenever fifo_empty=0 (show-ahead)
- fifo_rd  output  1  pop strobe to FIFO
- m_valid  output  1  stream word valid
- m_ready  input  1  downstream accept
- m_data  output  B  stream word
- m_last  output  1  final beat of a packet
- busy  output  1  state != IDLE
- word_cnt  output  CW  count of completed stream transfers

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- Reset values: state=IDLE, occ=0, beat counter=0, word_cnt=0, fifo_rd=0, m_valid=0, m_last=0, busy=0. m_data is don't-care at reset; drive 0.
- Buffer: entry0 (head) and entry1 (skid). occ ∈ {0,1,2} is registered.
- Definitions: m_valid = (occ != 0); m_data = entry0; pop = m_valid & m_ready.
- fifo_rd = (state==RUN) & ~fifo_empty & (occ < 2). It is combinational from registered state/occ and fifo_empty only; it never depends on m_ready.
- A push occurs when fifo_rd=1; fifo_data is captured at that same clock edge. Zero-latency show-ahead capture; the word appears on m_data the next cycle.
- Buffer update per edge:
  - occ=0, push: entry0 <= fifo_data, occ=1.
  - occ=1, push & pop: entry0 <= fifo_data, occ=1.
  - occ=1, push only: entry1 <= fifo_data, occ=2.
  - occ=1, pop only: occ=0.
  - occ=2, pop: entry0 <= entry1, occ=1. No push is possible at occ=2.
- Steady state: occ=1 with push and pop every cycle gives 1 word/clk throughput.
- While m_valid=1 and m_ready=0, m_data and m_last hold stable.
- Beat counter, width clog2(BURST), min 1 bit:
  - m_last = m_valid & (beat == BURST-1).
  - On pop: beat <= (beat == BURST-1) ? 0 : beat+1.
  - BURST=1: m_last=1 on every valid beat.
- word_cnt increments on every pop and wraps modulo 2^CW.
- FSM:
  - IDLE: enable=1 -> RUN.
  - RUN: fetch active. enable=0 -> DRAIN (takes effect next cycle; fifo_rd drops the cycle after enable falls).
  - DRAIN: no fetch. enable=1 -> RUN. Else, if occ==0, or occ==1 with pop this cycle -> IDLE.
- FIFO empty in RUN: fifo_rd=0, buffer drains normally, state stays RUN. The packet stays open (beat counter held).
- fifo_rd is never asserted while fifo_empty=1.
- Reset asserted mid-operation: buffer contents are discarded, outputs go to reset values immediately (asynchronous), and any partial packet is lost.

Optional Feature:
- Macro: FIFO_STREAM_READER_FLUSH_EN.
- Defined: in DRAIN, when occ==1 and beat != BURST-1, m_last is forced to 1 on that final buffered word. On its pop the beat counter resets to 0, so a partial packet is closed.
- Not defined: the partial packet stays open in DRAIN/IDLE. The beat counter holds across enable toggles and resumes on the next RUN.

Test Plan:
- Reset, enable=1, FIFO preloaded 0x01..0x08, m_ready=1:
  - fifo_rd high 8 consecutive cycles; m_data 0x01..0x08 on consecutive cycles.
  - m_last on 0x04 and 0x08; word_cnt=8; returns to occ=0 with state RUN.
- Same load, m_ready toggling 1,0,1,0:
  - No word lost or duplicated; m_data stable while stalled; occ never exceeds 2.
  - fifo_rd low whenever occ=2.
- enable=1, m_ready=0, 8 words in FIFO:
  - Exactly 2 fifo_rd pulses then fifo_rd stays 0.
  - Raise m_ready: words 0x01,0x02,… emitted in order.
- enable dropped after 6 words with 2 words buffered:
  - fifo_rd=0 from the next cycle; both buffered words emitted; DRAIN -> IDLE; busy=0.
  - Macro defined: m_last on word 6. Macro undefined: no m_last on word 6; after re-enable, m_last on word 8.
- rst_n pulsed low mid-stream with occ=2:
  - m_valid, fifo_rd, busy and word_cnt all 0 asynchronously.
  - After release, no stale data appears.
- BURST=1, CW=4, 20 words:
  - m_last on every beat; word_cnt wraps to 4 (20 mod 16).
